// File: rtl/mesh_local_inject_arb.sv
// Round-robin injection arbiter feeding a mesh router LOCAL input through one output register stage.
// Optional stall counter (stall_clr/stall_cnt ports) enabled by defining MESH_INJ_STALL_CNT_EN.
module mesh_local_inject_arb #(
  parameter int NUM_REQ   = 4,
  parameter int MESH_SIDE = 4,
  parameter int X_COORD   = 0,
  parameter int Y_COORD   = 0,
  parameter int COORD_W   = 3,
  parameter int DATA_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*COORD_W-1:0] req_dest_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_dest_y,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COORD_W:0]           out_s_delta_x,
  output logic [COORD_W:0]           out_s_delta_y,
  output logic [COORD_W-1:0]         out_dest_x,
  output logic [COORD_W-1:0]         out_dest_y,
  output logic [DATA_W-1:0]          out_data,
  output logic                       bad_dest
`ifdef MESH_INJ_STALL_CNT_EN
  ,
  input  logic                       stall_clr,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [COORD_W:0] X_EXT    = (COORD_W+1)'(X_COORD);
  localparam logic [COORD_W:0] Y_EXT    = (COORD_W+1)'(Y_COORD);
  localparam logic [COORD_W:0] SIDE_EXT = (COORD_W+1)'(MESH_SIDE);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [COORD_W:0]   sdx_q, sdx_d, sdy_q, sdy_d;
  logic [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               bad_q, bad_d;

  logic               can_accept, grant_any, accept, legal;
  logic [PTR_W-1:0]   grant_idx;
  logic [COORD_W-1:0] sel_dx, sel_dy;
  logic [DATA_W-1:0]  sel_data;

  // First valid requester at or after ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
  end

  assign can_accept = (state_q == ST_EMPTY) || out_ready;
  assign accept     = can_accept && grant_any && !rst;
  assign sel_dx     = req_dest_x[grant_idx*COORD_W +: COORD_W];
  assign sel_dy     = req_dest_y[grant_idx*COORD_W +: COORD_W];
  assign sel_data   = req_data[grant_idx*DATA_W +: DATA_W];
  assign legal      = ({1'b0, sel_dx} < SIDE_EXT) && ({1'b0, sel_dy} < SIDE_EXT);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      localparam logic [PTR_W-1:0] GI = PTR_W'(gi);
      assign req_ready[gi] = accept && (grant_idx == GI);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sdx_d   = sdx_q;
    sdy_d   = sdy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    data_d  = data_q;
    bad_d   = 1'b0;
    if (accept) begin
      ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
      if (legal) begin
        state_d = ST_FULL;
        sdx_d   = {1'b0, sel_dx} - X_EXT;
        sdy_d   = {1'b0, sel_dy} - Y_EXT;
        dx_d    = sel_dx;
        dy_d    = sel_dy;
        data_d  = sel_data;
      end else begin
        // Accepting implies the old flit (if any) drained, so the stage empties.
        state_d = ST_EMPTY;
        bad_d   = 1'b1;
      end
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sdx_q   <= '0;
      sdy_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      data_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sdx_q   <= sdx_d;
      sdy_q   <= sdy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      data_q  <= data_d;
      bad_q   <= bad_d;
    end
  end

  assign out_valid     = (state_q == ST_FULL);
  assign out_s_delta_x = sdx_q;
  assign out_s_delta_y = sdy_q;
  assign out_dest_x    = dx_q;
  assign out_dest_y    = dy_q;
  assign out_data      = data_q;
  assign bad_dest      = bad_q;

`ifdef MESH_INJ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Clear wins over increment; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stall_clr) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_FULL) && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mesh_local_inject_arb.sv
// Directed table-driven bench for mesh_local_inject_arb at node (1,2) of a 4x4 mesh.
module tb_mesh_local_inject_arb;

  localparam int NR = 4;
  localparam int CW = 3;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*CW-1:0]  req_dest_x;
  logic [NR*CW-1:0]  req_dest_y;
  logic [NR*DW-1:0]  req_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW:0]       out_s_delta_x;
  logic [CW:0]       out_s_delta_y;
  logic [CW-1:0]     out_dest_x;
  logic [CW-1:0]     out_dest_y;
  logic [DW-1:0]     out_data;
  logic              bad_dest;
`ifdef MESH_INJ_STALL_CNT_EN
  logic              stall_clr;
  logic [15:0]       stall_cnt;
`endif

  mesh_local_inject_arb #(
    .NUM_REQ(NR), .MESH_SIDE(4), .X_COORD(1), .Y_COORD(2), .COORD_W(CW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s_delta_x(out_s_delta_x), .out_s_delta_y(out_s_delta_y),
    .out_dest_x(out_dest_x), .out_dest_y(out_dest_y),
    .out_data(out_data), .bad_dest(bad_dest)
`ifdef MESH_INJ_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  v;
    logic        ordy;
    logic [11:0] dx;
    logic [11:0] dy;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [3:0]  e_sdx;
    logic [3:0]  e_sdy;
    logic [2:0]  e_dx;
    logic [2:0]  e_dy;
    logic [31:0] e_data;
    logic        e_bad;
  } vec_t;

  // Requester dests: r0 (3,0), r1 (0,3), r2 (1,2) = own node, r3 (2,1).
  localparam logic [11:0] DXN = {3'd2, 3'd1, 3'd0, 3'd3};
  localparam logic [11:0] DYN = {3'd1, 3'd2, 3'd3, 3'd0};
  localparam logic [11:0] DXB = {3'd2, 3'd5, 3'd0, 3'd3};  // r2 x=5 out of range
  localparam logic [11:0] DYB = {3'd1, 3'd2, 3'd3, 3'd4};  // r0 y=4 out of range

  int errors = 0;
  int checks = 0;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic ordy, input logic [11:0] dx,
                              input logic [11:0] dy, input logic [3:0] e_rdy, input logic e_val,
                              input int g, input logic e_bad);
    vec_t r;
    r.v = v; r.ordy = ordy; r.dx = dx; r.dy = dy;
    r.e_rdy = e_rdy; r.e_val = e_val; r.e_bad = e_bad;
    case (g)
      0:       begin r.e_sdx = 4'h2; r.e_sdy = 4'hE; r.e_dx = 3'd3; r.e_dy = 3'd0; r.e_data = 32'hA5A5_0001; end
      1:       begin r.e_sdx = 4'hF; r.e_sdy = 4'h1; r.e_dx = 3'd0; r.e_dy = 3'd3; r.e_data = 32'hA5A5_0002; end
      2:       begin r.e_sdx = 4'h0; r.e_sdy = 4'h0; r.e_dx = 3'd1; r.e_dy = 3'd2; r.e_data = 32'hA5A5_0003; end
      3:       begin r.e_sdx = 4'h1; r.e_sdy = 4'hF; r.e_dx = 3'd2; r.e_dy = 3'd1; r.e_data = 32'hA5A5_0004; end
      default: begin r.e_sdx = 4'h0; r.e_sdy = 4'h0; r.e_dx = 3'd0; r.e_dy = 3'd0; r.e_data = 32'h0; end
    endcase
    return r;
  endfunction

  task automatic check_out(input string tag, input logic e_val, input int g_unused_dummy,
                           input logic [3:0] e_sdx, input logic [3:0] e_sdy, input logic [2:0] e_dx,
                           input logic [2:0] e_dy, input logic [31:0] e_data, input logic e_bad);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_val));
    chk({tag, " bad_dest"}, 32'(bad_dest), 32'(e_bad));
    if (e_val) begin
      chk({tag, " s_delta_x"}, 32'(out_s_delta_x), 32'(e_sdx));
      chk({tag, " s_delta_y"}, 32'(out_s_delta_y), 32'(e_sdy));
      chk({tag, " dest_x"}, 32'(out_dest_x), 32'(e_dx));
      chk({tag, " dest_y"}, 32'(out_dest_y), 32'(e_dy));
      chk({tag, " data"}, out_data, e_data);
    end
  endtask

  initial begin
    vecs[0]  = mk(4'b0001, 1'b1, DXN, DYN, 4'b0001, 1'b1, 0, 1'b0);  // single requester
    vecs[1]  = mk(4'b1111, 1'b1, DXN, DYN, 4'b0010, 1'b1, 1, 1'b0);  // round robin 1,2,3,0
    vecs[2]  = mk(4'b1111, 1'b1, DXN, DYN, 4'b0100, 1'b1, 2, 1'b0);  // self-addressed
    vecs[3]  = mk(4'b1111, 1'b1, DXN, DYN, 4'b1000, 1'b1, 3, 1'b0);
    vecs[4]  = mk(4'b1111, 1'b1, DXN, DYN, 4'b0001, 1'b1, 0, 1'b0);
    vecs[5]  = mk(4'b0000, 1'b1, DXN, DYN, 4'b0000, 1'b0, -1, 1'b0); // drain, ptr holds at 1
    vecs[6]  = mk(4'b0001, 1'b1, DXN, DYN, 4'b0001, 1'b1, 0, 1'b0);  // wrap search from ptr 1
    for (int i = 7; i < 12; i++)
      vecs[i] = mk(4'b0110, 1'b0, DXN, DYN, 4'b0000, 1'b1, 0, 1'b0); // 5 cycles backpressure
    vecs[12] = mk(4'b0110, 1'b1, DXN, DYN, 4'b0010, 1'b1, 1, 1'b0);  // release: req1, no bubble
    vecs[13] = mk(4'b0000, 1'b1, DXN, DYN, 4'b0000, 1'b0, -1, 1'b0);
    vecs[14] = mk(4'b0100, 1'b1, DXB, DYN, 4'b0100, 1'b0, -1, 1'b1); // illegal x from empty
    vecs[15] = mk(4'b0000, 1'b1, DXN, DYN, 4'b0000, 1'b0, -1, 1'b0); // pulse is one cycle
    vecs[16] = mk(4'b1111, 1'b1, DXN, DYN, 4'b1000, 1'b1, 3, 1'b0);  // ptr advanced to 3
    vecs[17] = mk(4'b0001, 1'b1, DXN, DYB, 4'b0001, 1'b0, -1, 1'b1); // illegal y while draining
    vecs[18] = mk(4'b0000, 1'b1, DXN, DYN, 4'b0000, 1'b0, -1, 1'b0);
    vecs[19] = mk(4'b0000, 1'b1, DXN, DYN, 4'b0000, 1'b0, -1, 1'b0);

    rst        = 1'b1;
    req_valid  = 4'b1111;
    out_ready  = 1'b0;
    req_dest_x = DXN;
    req_dest_y = DYN;
    req_data   = {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};
`ifdef MESH_INJ_STALL_CNT_EN
    stall_clr  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset bad_dest", 32'(bad_dest), 32'h0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset s_delta_x", 32'(out_s_delta_x), 32'h0);
    chk("reset dest_y", 32'(out_dest_y), 32'h0);
    rst       = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      req_valid  = vecs[i].v;
      out_ready  = vecs[i].ordy;
      req_dest_x = vecs[i].dx;
      req_dest_y = vecs[i].dy;
      @(negedge clk);
      chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].e_val, 0, vecs[i].e_sdx, vecs[i].e_sdy,
                vecs[i].e_dx, vecs[i].e_dy, vecs[i].e_data, vecs[i].e_bad);
      $display("vec %0d: valid=%b ready=%b out_valid=%b data=%h bad=%b",
               i, vecs[i].v, req_ready, out_valid, out_data, bad_dest);
`ifdef MESH_INJ_STALL_CNT_EN
      if (i == 11) chk("stall_cnt after 5 stalls", 32'(stall_cnt), 32'd5);
      if (i == 12) chk("stall_cnt after release", 32'(stall_cnt), 32'd5);
`endif
    end

    // Reset mid-flight: load req2 (ptr=1), hold it under backpressure, then reset.
    req_valid  = 4'b0100;
    out_ready  = 1'b1;
    req_dest_x = DXN;
    req_dest_y = DYN;
    @(negedge clk);
    chk("rstseq grant req_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    check_out("rstseq load", 1'b1, 0, 4'h0, 4'h0, 3'd1, 3'd2, 32'hA5A5_0003, 1'b0);
    $display("rstseq load: out_valid=%b data=%h", out_valid, out_data);
    req_valid = 4'b0000;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstseq out_valid after rst", 32'(out_valid), 32'h0);
    chk("rstseq req_ready after rst", 32'(req_ready), 32'h0);
    chk("rstseq bad_dest after rst", 32'(bad_dest), 32'h0);
    $display("rstseq reset: out_valid=%b req_ready=%b", out_valid, req_ready);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("rstseq ptr0 lowest grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    check_out("rstseq regrant", 1'b1, 0, 4'hF, 4'h1, 3'd0, 3'd3, 32'hA5A5_0002, 1'b0);
    $display("rstseq regrant: out_valid=%b data=%h", out_valid, out_data);
    @(negedge clk);
    chk("rstseq backpressure ready", 32'(req_ready), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mesh_local_inject_arb.md
Name: mesh_local_inject_arb

Overview:
- Shares one router LOCAL input port among NUM_REQ local requesters (cores/DMA) at mesh node (X_COORD, Y_COORD).
- Arbitration is round-robin.
- For each granted flit, the block computes the signed hop deltas s_delta_x and s_delta_y from the destination and the node's own coordinates.
- A single output register stage drives the router_if-style LOCAL input: s_delta_x, s_delta_y, dest_x, dest_y, data, valid, ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MESH_SIDE, 4, mesh dimension; legal coordinates are 0..MESH_SIDE-1.
- X_COORD, 0, X coordinate of this node.
- Y_COORD, 0, Y coordinate of this node.
- COORD_W, 3, coordinate width in bits; must satisfy 2**COORD_W >= MESH_SIDE.
- DATA_W, 32, payload width.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_dest_x  in  NUM_REQ*COORD_W  destination X; requester k occupies slice [k*COORD_W +: COORD_W].
- req_dest_y  in  NUM_REQ*COORD_W  destination Y; same packing.
- req_data  in  NUM_REQ*DATA_W  payload; same packing.
- out_valid  out  1  flit valid toward the router LOCAL input.
- out_ready  in  1  router LOCAL input accepts the flit.
- out_s_delta_x  out  COORD_W+1  signed dest_x - X_COORD.
- out_s_delta_y  out  COORD_W+1  signed dest_y - Y_COORD.
- out_dest_x  out  COORD_W  registered destination X.
- out_dest_y  out  COORD_W  registered destination Y.
- out_data  out  DATA_W  registered payload.
- bad_dest  out  1  one-cycle pulse when an out-of-range flit is discarded.

Behaviour:
- Reset values: out_valid=0; all out_* data fields=0; bad_dest=0; req_ready=0; round-robin pointer ptr=0.
- Reset taking effect mid-operation discards any held flit with no handshake.
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Accept condition: can_accept = EMPTY, or (FULL and out_ready). This gives back-to-back throughput of 1 flit/cycle.
- Grant:
  - When can_accept, grant the first requester with req_valid=1, searching ptr, ptr+1, … with wrap-around mod NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle only. All other req_ready bits are 0.
  - req_ready depends on req_valid and out_ready, never on itself.
- On accept of requester g:
  - ptr <= (g+1) mod NUM_REQ. ptr is unchanged when nothing is accepted.
  - Legal destination: register dest, data and deltas; state -> FULL; out_valid=1 on the next cycle (latency 1).
- Delta arithmetic:
  - Zero-extend both operands to COORD_W+1 bits, then subtract in two's complement.
  - Example: dest_x=0, X_COORD=3, COORD_W=3 gives 4'b1101 (-3).
  - dest equal to own coordinates gives deltas of 0; the flit is still forwarded so the router ejects it locally.
- Illegal destination (dest_x >= MESH_SIDE or dest_y >= MESH_SIDE):
  - The flit is still accepted (req_ready=1) and ptr still advances.
  - It is not forwarded; bad_dest=1 on the next cycle.
  - The output stage is then EMPTY if the previous flit drained that cycle, otherwise it stays FULL holding the old flit unchanged.
- FULL and !out_ready: all out_* fields are held stable and req_ready=0 (backpressure).
- FULL and out_ready with no new grant: state -> EMPTY, out_valid=0.
- Simultaneous drain and accept: the register is overwritten with the new flit, out_valid stays 1, and no bubble is inserted.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.

Optional Feature:
- Macro: MESH_INJ_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits.
  - Counts cycles with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF; reset value 0.
  - Also clears synchronously when input port stall_clr=1. stall_clr has priority over increment in the same cycle.
- Not defined: neither port exists, and there is no counter logic.

Test Plan:
- Single requester, MESH_SIDE=4, X_COORD=1, Y_COORD=2:
  - req 0 sends dest(3,0), data 32'hA5A5_0001, out_ready=1.
  - Required: req_ready[0]=1 in the same cycle; the next cycle shows out_valid=1, s_delta_x=+2 (4'b0010), s_delta_y=-2 (4'b1110), data 32'hA5A5_0001.
- All 4 requesters valid continuously, out_ready=1:
  - Required grant order 0,1,2,3,0,1…; one flit per cycle with no bubbles.
  - ptr holds on cycles where all req_valid=0.
- Backpressure:
  - Flit loaded, out_ready=0 for 5 cycles while req 1 and req 2 are valid.
  - Required: out_* stable and req_ready=0 throughout; on the cycle out_ready rises, req 1 is granted and out_valid stays 1.
  - With MESH_INJ_STALL_CNT_EN defined, stall_cnt=5.
- Illegal destination:
  - req 2 sends dest_x=5 with MESH_SIDE=4.
  - Required: req_ready[2]=1; bad_dest pulses exactly 1 cycle; out_valid stays 0; ptr=3.
- Reset mid-flight:
  - rst=1 for one cycle while FULL with out_ready=0.
  - Required: next cycle out_valid=0, req_ready=0, ptr=0; the next grant goes to the lowest valid index.
- Self-addressed flit:
  - dest equal to (X_COORD, Y_COORD).
  - Required: forwarded with s_delta_x=s_delta_y=0; bad_dest=0.
